// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  // Requester 0 (fetch / load-store unit)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rsp_valid;

  // Requester 1 (debug / DMA loader)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rsp_valid;

  // Shared read response
  logic [DATA_W-1:0] rsp_rdata;

  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rsp_valid,
    output m1_gnt, m1_rsp_valid,
    output rsp_rdata,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rsp_valid,
    input  m1_gnt, m1_rsp_valid,
    input  rsp_rdata,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port
// synchronous memory with a 1-cycle registered read. One access is in
// flight at a time: grant (IDLE) -> ISSUE -> CAPTURE -> response in IDLE,
// giving one access every 3 cycles and a grant-to-response latency of 3.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Arbitration bookkeeping
  logic              r_last_grant;   // index of the most recently granted requester
  logic              r_owner;        // requester that owns the in-flight access
  logic              r_is_read;      // in-flight access is a read

  // Memory-side registers
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_re;
  logic              r_mem_we;

  // Response registers
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_valid0;
  logic              r_rsp_valid1;

  // Combinational arbitration / FSM outputs
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;
  logic              w_gnt_idx;
  logic              w_capture;
  logic              w_busy;

  // Selected request fields of the winning requester
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Round-robin grant: only in IDLE; on a tie the requester that was not
  // granted last time wins, so two busy requesters alternate.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      w_gnt0 = bus.m0_req & (~bus.m1_req |  r_last_grant);
      w_gnt1 = bus.m1_req & (~bus.m0_req | ~r_last_grant);
    end
  end

  assign w_grant   = w_gnt0 | w_gnt1;
  assign w_gnt_idx = w_gnt1;

  // Mux the winning requester's fields; only meaningful when w_grant is high.
  always_comb begin
    w_sel_we    = bus.m0_we;
    w_sel_addr  = bus.m0_addr;
    w_sel_wdata = bus.m0_wdata;
    if (w_gnt_idx) begin
      w_sel_we    = bus.m1_we;
      w_sel_addr  = bus.m1_addr;
      w_sel_wdata = bus.m1_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and per-state decodes; only leaving IDLE needs a grant.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Arbitration bookkeeping, captured on the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_is_read    <= 1'b0;
    end else if (w_grant) begin
      r_last_grant <= w_gnt_idx;
      r_owner      <= w_gnt_idx;
      r_is_read    <= ~w_sel_we;
    end
  end

  // Memory command registers: enables are high only during ISSUE, while
  // address and write data hold their last values between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_re <= w_grant & ~w_sel_we;
      r_mem_we <= w_grant &  w_sel_we;
      if (w_grant) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  // Response: capture read data at the end of CAPTURE and pulse the owner's
  // valid for the following (IDLE) cycle; writes leave the read data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata  <= '0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
    end else begin
      r_rsp_valid0 <= w_capture & ~r_owner;
      r_rsp_valid1 <= w_capture &  r_owner;
      if (w_capture && r_is_read) begin
        r_rsp_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.m0_gnt       = w_gnt0;
  assign bus.m1_gnt       = w_gnt1;
  assign bus.m0_rsp_valid = r_rsp_valid0;
  assign bus.m1_rsp_valid = r_rsp_valid1;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_re       = r_mem_re;
  assign bus.mem_we       = r_mem_we;
  assign bus.busy         = w_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single accesses plus hand-written
// sequences for ties, contention, back-to-back reads, write responses and
// reset in the middle of an access. Responses are checked from a queue of
// expectations pushed at each grant.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 256x16 synchronous memory with registered read data
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  typedef struct {
    logic          who;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  typedef struct {
    logic          who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  exp_t          sbq[$];
  vec_t          vecs[10];
  int            n_vec  = 0;
  int            n_miss = 0;
  int            cyc    = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response for a grant observed in the current cycle.
  task automatic push(input logic who, input logic we, input logic [DW-1:0] rd);
    exp_t e;
    if (!we) last_rd = rd;
    e.who   = who;
    e.rdata = last_rd;
    e.due   = cyc + 3;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (sbq.size() != 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      chk("rsp_missing", cyc, e.due);
    end
    if (bus.m0_rsp_valid || bus.m1_rsp_valid) begin
      if (bus.m0_rsp_valid && bus.m1_rsp_valid)
        chk("rsp_onehot", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 2'b01);
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 2'b00);
      end else begin
        e = sbq.pop_front();
        chk("rsp_who", bus.m1_rsp_valid, e.who);
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    monitor();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  task automatic drive(input logic who, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end
  endtask

  // One complete access with cycle-by-cycle checks of the memory command.
  task automatic access(input logic who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    bit got = 1'b0;
    drive(who, 1'b1, we, a, d);
    for (int i = 0; i < 10; i++) begin
      settle();
      if (who ? bus.m1_gnt : bus.m0_gnt) begin
        got = 1'b1;
        break;
      end
      advance();
    end
    chk("gnt_seen", got, 1);
    if (got) begin
      chk("gnt_other", who ? bus.m0_gnt : bus.m1_gnt, 0);
      push(who, we, exp_rd);
      advance();
      drive(who, 1'b0, ~we, ~a, ~d);
      settle();
      chk("issue_re", bus.mem_re, !we);
      chk("issue_we", bus.mem_we, we);
      chk("issue_addr", bus.mem_addr, a);
      if (we) chk("issue_wdata", bus.mem_wdata, d);
      chk("issue_busy", bus.busy, 1);
      advance();
      settle();
      chk("capture_en", {bus.mem_re, bus.mem_we}, 2'b00);
      chk("capture_busy", bus.busy, 1);
      advance();
      settle();
      chk("rsp_en", {bus.mem_re, bus.mem_we}, 2'b00);
      chk("rsp_busy", bus.busy, 0);
      chk("hold_addr", bus.mem_addr, a);
      advance();
    end else begin
      drive(who, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    advance();
    advance();
    rst_n   = 1'b1;
    sbq.delete();
    last_rd = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 8'h00, 16'h1234, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 16'hABCD, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 8'h80, 16'h5A5A, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 8'h80, 16'h0000, 16'h5A5A};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hABCD};
    vecs[7] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[8] = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0000};
    vecs[9] = '{1'b0, 1'b0, 8'h01, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    advance();
    settle();
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_en", {bus.mem_re, bus.mem_we}, 2'b00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_valid", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 2'b00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
    advance();
    rst_n = 1'b1;

    // Table of single accesses
    for (int i = 0; i < 10; i++)
      access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // Tie right after reset: m0 first, m1 three cycles later
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h80, '0);
    settle();
    chk("tie_g0", bus.m0_gnt, 1);
    chk("tie_g1", bus.m1_gnt, 0);
    push(1'b0, 1'b0, 16'hBEEF);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k < 3; k++) begin
      settle();
      chk("tie_wait_g1", bus.m1_gnt, 0);
      chk("tie_wait_busy", bus.busy, 1);
      advance();
    end
    settle();
    chk("tie_late_g1", bus.m1_gnt, 1);
    chk("tie_late_g0", bus.m0_gnt, 0);
    push(1'b1, 1'b0, 16'h5A5A);
    advance();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(3);

    // Continuous contention: four grants alternating m0, m1, m0, m1
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 8'hFF, '0);
    for (int k = 0; k < 13; k++) begin
      settle();
      chk("cont_g0", bus.m0_gnt, (k < 12) && (k % 3 == 0) && ((k / 3) % 2 == 0));
      chk("cont_g1", bus.m1_gnt, (k < 12) && (k % 3 == 0) && ((k / 3) % 2 == 1));
      chk("cont_busy", bus.busy, (k % 3) != 0);
      if (k < 12 && k % 3 == 0)
        push(((k / 3) % 2) == 1, 1'b0, ((k / 3) % 2 == 1) ? 16'hABCD : 16'hBEEF);
      advance();
      if (k == 9) begin
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end

    // Back-to-back m1 reads, grants exactly 3 cycles apart
    drive(1'b1, 1'b1, 1'b0, 8'h00, '0);
    settle();
    chk("b2b_g1_first", bus.m1_gnt, 1);
    push(1'b1, 1'b0, 16'h1234);
    advance();
    drive(1'b1, 1'b1, 1'b0, 8'hFF, '0);
    for (int k = 1; k < 3; k++) begin
      settle();
      chk("b2b_g1_gap", bus.m1_gnt, 0);
      advance();
    end
    settle();
    chk("b2b_g1_second", bus.m1_gnt, 1);
    push(1'b1, 1'b0, 16'hABCD);
    advance();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(3);

    // Write response keeps rsp_rdata; later read returns the written value
    access(1'b1, 1'b1, 8'h20, 16'h0055, 16'h0000);
    access(1'b0, 1'b0, 8'h20, 16'h0000, 16'h0055);

    // Reset during ISSUE of a read
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    settle();
    chk("rmid_g0", bus.m0_gnt, 1);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    settle();
    chk("rmid_issue_re", bus.mem_re, 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_re_drop", bus.mem_re, 0);
    chk("rmid_we_drop", bus.mem_we, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_rsp", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 2'b00);
    advance();
    settle();
    chk("rmid_hold_quiet", {bus.m1_rsp_valid, bus.m0_rsp_valid, bus.busy}, 3'b000);
    advance();
    rst_n = 1'b1;
    sbq.delete();
    last_rd = '0;
    idle_cycles(3);
    drive(1'b0, 1'b1, 1'b0, 8'h10, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h80, '0);
    settle();
    chk("rmid_tie_g0", bus.m0_gnt, 1);
    chk("rmid_tie_g1", bus.m1_gnt, 0);
    push(1'b0, 1'b0, 16'hBEEF);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(4);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port 256x16 synchronous data memory.
- Requester 0 is the fetch/load-store unit; requester 1 is the debug/DMA loader.
- Accepts one request at a time, drives the memory's address, write-data, read-enable and write-enable, and absorbs the memory's 1-cycle registered read latency.
- Returns a response pulse, plus read data, to the owning requester.

Parameters:
- ADDR_W, 8, memory address width (depth 2^ADDR_W)
- DATA_W, 16, memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request
- m0_we  in  1  requester 0 access type: 1=write, 0=read
- m0_addr  in  ADDR_W  requester 0 address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  requester 0 request accepted this cycle (combinational)
- m0_rsp_valid  out  1  requester 0 access complete, 1-cycle pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rsp_valid  same as m0_*, for requester 1
- rsp_rdata  out  DATA_W  read data of the most recent read response (shared)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_re  out  1  memory read enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_re
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), owner=0, is_read=0.
  - mem_addr=0, mem_wdata=0, mem_re=0, mem_we=0.
  - rsp_rdata=0, m0_rsp_valid=m1_rsp_valid=0.
- FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE. Transitions are unconditional except out of IDLE, which needs a grant.
- Grant in IDLE only:
  - m0_gnt = IDLE & m0_req & (!m1_req | last_grant==1).
  - m1_gnt = IDLE & m1_req & (!m0_req | last_grant==0).
  - At most one grant per cycle; no grant in ISSUE or CAPTURE.
- Grant edge (cycle T):
  - Register the granted requester's addr into mem_addr, wdata into mem_wdata, and we into is_read (inverted).
  - Set mem_re=!we and mem_we=we; owner=granted index; last_grant=granted index; go to ISSUE.
- ISSUE (T+1): mem_re or mem_we is high for exactly this one cycle; the memory performs the access at the end-of-cycle edge. Clear both enables on exit.
- CAPTURE (T+2): if is_read, rsp_rdata <= mem_rdata at the end of the cycle. Set rsp_valid of the owner for the next cycle.
- IDLE (T+3):
  - The owner's rsp_valid is high for exactly one cycle.
  - A new grant may occur in this same cycle, so throughput is one access per 3 cycles.
  - Read latency is grant to rsp_valid = 3 cycles.
- Write responses also pulse rsp_valid; rsp_rdata is unchanged on writes.
- rsp_rdata holds its value until the next read completes.
- The requester holds req/we/addr/wdata stable until it sees gnt. Changes before gnt are allowed; values are sampled only at the grant edge.
- A requester holding req continuously after its grant re-arbitrates at T+3; round-robin then alternates if both requesters are active.
- mem_addr and mem_wdata hold their last values when idle.
- Address wrap: none; the full 0..2^ADDR_W-1 range is passed through unchanged.
- Reset mid-operation: the in-flight access is abandoned and no rsp_valid is issued. mem_re and mem_we drop immediately.
  - A write already in ISSUE at the reset edge may or may not land; the bench must not rely on either outcome.
- A request arriving while busy waits; there is no queue and no loss as long as req is held.

Test Plan:
- Single write then read, m0: write addr 0x10 data 0xBEEF, then read 0x10. m0_gnt at T, mem_we=1 only at T+1, m0_rsp_valid at T+3; read returns rsp_rdata=0xBEEF with m0_rsp_valid 3 cycles after its grant.
- Tie after reset: m0 and m1 both request reads at the same cycle. m0_gnt first, m1_gnt 3 cycles later; the 4th cycle after the first grant shows m1 pending, m0 idle.
- Continuous contention: m0 and m1 hold req for 4 accesses. Grants alternate m0,m1,m0,m1 every 3 cycles; busy never drops for more than the grant cycle.
- Back-to-back reads by m1: addr 0x00 then 0xFF, preloaded 0x1234 and 0xABCD. rsp_rdata=0x1234 then 0xABCD; grants spaced exactly 3 cycles; m0_rsp_valid never asserts.
- Write response: m1 writes 0x0055 to 0x20 while rsp_rdata=0xABCD. m1_rsp_valid pulses, rsp_rdata stays 0xABCD, and a later read of 0x20 returns 0x0055.
- Reset in ISSUE: assert rst_n=0 mid-access of a read. mem_re=0 immediately, no rsp_valid, state IDLE; after release, m0 wins a tie.
